// File: rtl/ddr_pkg.sv
// Shared types and constants for the ddr_judge timing judge.
// Optional feature macro: DDR_JUDGE_COMBO_BONUS_EN (see ddr_judge.sv).
package ddr_pkg;

    typedef enum logic [1:0] {
        J_NONE,
        J_PERFECT,
        J_GOOD,
        J_MISS
    } judge_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_FINISHED
    } state_e;

    localparam logic [15:0] PTS_PERFECT = 16'd3;
    localparam logic [15:0] PTS_GOOD    = 16'd1;

    // Bit positions inside the 4-bit direction vector {LEFT, RIGHT, UP, DOWN}
    localparam int unsigned DIR_LEFT  = 3;
    localparam int unsigned DIR_RIGHT = 2;
    localparam int unsigned DIR_UP    = 1;
    localparam int unsigned DIR_DOWN  = 0;

    // Saturating 8-bit increment (combo counter)
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

endpackage

// File: rtl/ddr_edge_detect.sv
// 4-bit two-register rising-edge detector with synchronous reset.
// The first cycle after reset loads both copies from the input so that a
// button held through reset never produces a rise.
module ddr_edge_detect (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] d_i,
    output logic [3:0] rise_o
);

    logic [3:0] d1_q;
    logic [3:0] d2_q;
    logic       primed_q;

    // Two-stage history of the input; both stages seeded on the first post-reset cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d1_q     <= '0;
            d2_q     <= '0;
            primed_q <= 1'b0;
        end else if (!primed_q) begin
            d1_q     <= d_i;
            d2_q     <= d_i;
            primed_q <= 1'b1;
        end else begin
            d1_q <= d_i;
            d2_q <= d1_q;
        end
    end

    assign rise_o = d1_q & ~d2_q;

endmodule

// File: rtl/ddr_judge.sv
// Timing judge and scorer for the DDR pad game.
// Optional feature: define DDR_JUDGE_COMBO_BONUS_EN to add a combo bonus of
// min(combo, 15) / 4 points to each PERFECT.
module ddr_judge
    import ddr_pkg::*;
#(
    parameter int unsigned PERFECT_WIN = 100,
    parameter int unsigned GOOD_WIN    = 250
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic        start_i,
    input  logic        tgt_left_i,
    input  logic        tgt_right_i,
    input  logic        tgt_up_i,
    input  logic        tgt_down_i,
    input  logic        lvl_done_i,
    input  logic [3:0]  btn_i,
    output logic        hit_perfect_o,
    output logic        hit_good_o,
    output logic        hit_miss_o,
    output logic [15:0] score_o,
    output logic [7:0]  combo_o,
    output logic [7:0]  max_combo_o,
    output logic        final_o
);

    localparam int unsigned     AW = $clog2(GOOD_WIN + 1);
    localparam logic [AW-1:0]   PW = AW'(PERFECT_WIN);
    localparam logic [AW-1:0]   GW = AW'(GOOD_WIN);

    logic [3:0]    tgt_vec;
    logic          tgt_valid;
    logic [3:0]    rise;
    judge_e        judge;
    logic [15:0]   pts;
    logic [16:0]   sum;

    state_e        state_q;
    logic [3:0]    pend_q;
    logic [AW-1:0] age_q;
    logic [15:0]   score_q, score_d;
    logic [7:0]    combo_q, combo_d;
    logic [7:0]    maxc_q, maxc_d;
    logic          final_q;
    logic          perfect_q, good_q, miss_q;

    ddr_edge_detect u_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (btn_i),
        .rise_o (rise)
    );

    // Assemble the target vector; only an exact one-hot vector is a target
    always_comb begin
        tgt_vec            = '0;
        tgt_vec[DIR_LEFT]  = tgt_left_i;
        tgt_vec[DIR_RIGHT] = tgt_right_i;
        tgt_vec[DIR_UP]    = tgt_up_i;
        tgt_vec[DIR_DOWN]  = tgt_down_i;
        tgt_valid          = $onehot(tgt_vec);
    end

    // Judge the pending arrow: a press wins over timeout, which wins over eviction
    always_comb begin
        judge = J_NONE;
        if (state_q == S_ARMED) begin
            if (|rise) begin
                if (rise == pend_q)
                    judge = (age_q <= PW) ? J_PERFECT : J_GOOD;
                else
                    judge = J_MISS;
            end else if (tick_i && (age_q == GW)) begin
                judge = J_MISS;
            end else if (lvl_done_i || tgt_valid) begin
                judge = J_MISS;
            end
        end
    end

`ifdef DDR_JUDGE_COMBO_BONUS_EN
    logic [3:0] capped;
    always_comb capped = (combo_q > 8'd15) ? 4'd15 : combo_q[3:0];
`endif

    // Points, saturating score, combo and max-combo for this cycle's judgement
    always_comb begin
        pts = '0;
        unique case (judge)
`ifdef DDR_JUDGE_COMBO_BONUS_EN
            J_PERFECT: pts = PTS_PERFECT + 16'(capped >> 2);
`else
            J_PERFECT: pts = PTS_PERFECT;
`endif
            J_GOOD:    pts = PTS_GOOD;
            default:   pts = '0;
        endcase
        sum     = {1'b0, score_q} + {1'b0, pts};
        score_d = sum[16] ? '1 : sum[15:0];
        combo_d = combo_q;
        if (judge == J_PERFECT || judge == J_GOOD)
            combo_d = sat_inc8(combo_q);
        else if (judge == J_MISS)
            combo_d = '0;
        maxc_d = (combo_d > maxc_q) ? combo_d : maxc_q;
    end

    // Judge FSM with registered outputs; reset and start clear identically
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            age_q     <= '0;
            score_q   <= '0;
            combo_q   <= '0;
            maxc_q    <= '0;
            final_q   <= 1'b0;
            perfect_q <= 1'b0;
            good_q    <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            perfect_q <= (judge == J_PERFECT);
            good_q    <= (judge == J_GOOD);
            miss_q    <= (judge == J_MISS);
            score_q   <= score_d;
            combo_q   <= combo_d;
            maxc_q    <= maxc_d;
            unique case (state_q)
                S_IDLE: begin
                    if (lvl_done_i) begin
                        state_q <= S_FINISHED;
                        final_q <= 1'b1;
                    end else if (tgt_valid) begin
                        state_q <= S_ARMED;
                        pend_q  <= tgt_vec;
                        age_q   <= '0;
                    end
                end
                S_ARMED: begin
                    if (lvl_done_i) begin
                        state_q <= S_FINISHED;
                        final_q <= 1'b1;
                        pend_q  <= '0;
                        age_q   <= '0;
                    end else if (tgt_valid) begin
                        // Old arrow already judged this cycle; re-arm with the new one
                        pend_q <= tgt_vec;
                        age_q  <= '0;
                    end else if (judge != J_NONE) begin
                        state_q <= S_IDLE;
                        pend_q  <= '0;
                        age_q   <= '0;
                    end else if (tick_i) begin
                        age_q <= age_q + AW'(1);
                    end
                end
                S_FINISHED: begin
                    state_q <= S_FINISHED;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hit_perfect_o = perfect_q;
    assign hit_good_o    = good_q;
    assign hit_miss_o    = miss_q;
    assign score_o       = score_q;
    assign combo_o       = combo_q;
    assign max_combo_o   = maxc_q;
    assign final_o       = final_q;

endmodule

// File: tb/tb_ddr_judge.sv
// Scoreboard testbench for ddr_judge: stimulus pushes expected judgements,
// a negedge monitor pops and compares whenever a hit pulse appears.
module tb_ddr_judge;

    logic        clk = 1'b0;
    logic        rst, tick, start, tl, tr, tu, td, lvl_done;
    logic [3:0]  btn;
    logic        hp, hg, hm, fin;
    logic [15:0] score;
    logic [7:0]  combo, maxc;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    localparam logic [2:0] H_P = 3'b100;
    localparam logic [2:0] H_G = 3'b010;
    localparam logic [2:0] H_M = 3'b001;

    typedef struct {
        logic [2:0]  hits;
        logic [15:0] score;
        logic [7:0]  combo;
        logic [7:0]  maxc;
        logic        fin;
        int          at;
    } exp_t;

    exp_t q[$];

    ddr_judge #(.PERFECT_WIN(100), .GOOD_WIN(250)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_i       (tick),
        .start_i      (start),
        .tgt_left_i   (tl),
        .tgt_right_i  (tr),
        .tgt_up_i     (tu),
        .tgt_down_i   (td),
        .lvl_done_i   (lvl_done),
        .btn_i        (btn),
        .hit_perfect_o(hp),
        .hit_good_o   (hg),
        .hit_miss_o   (hm),
        .score_o      (score),
        .combo_o      (combo),
        .max_combo_o  (maxc),
        .final_o      (fin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every hit pulse must match the oldest expected judgement
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && (hp === 1'b1 || hg === 1'b1 || hm === 1'b1)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got p/g/m=%b at cycle %0d, expected no pulse",
                         {hp, hg, hm}, cyc);
            end else begin
                e = q.pop_front();
                if ({hp, hg, hm} !== e.hits || score !== e.score || combo !== e.combo ||
                    maxc !== e.maxc || fin !== e.fin || cyc != e.at) begin
                    errors++;
                    $display("FAIL judgement: got pgm=%b score=%0d combo=%0d max=%0d final=%b cyc=%0d, expected pgm=%b score=%0d combo=%0d max=%0d final=%b cyc=%0d",
                             {hp, hg, hm}, score, combo, maxc, fin, cyc,
                             e.hits, e.score, e.combo, e.maxc, e.fin, e.at);
                end
            end
        end
    end

    task automatic expect_hit(input logic [2:0] h, input int s, input int c, input int m,
                              input logic f, input int at);
        exp_t e;
        e.hits  = h;
        e.score = 16'(s);
        e.combo = 8'(c);
        e.maxc  = 8'(m);
        e.fin   = f;
        e.at    = at;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic pulse_tgt(input logic [3:0] v);
        {tl, tr, tu, td} = v;
        @(negedge clk);
        {tl, tr, tu, td} = '0;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [3:0] v);
        btn = v;
        repeat (2) @(negedge clk);
        btn = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; btn = 4'hF; tick = 1'b0; start = 1'b0;
        {tl, tr, tu, td} = '0; lvl_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hits",  int'({hp, hg, hm}), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_combo", int'(combo), 0);
        chk("rst_max",   int'(maxc), 0);
        chk("rst_final", int'(fin), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        btn = '0;
        repeat (3) @(negedge clk);
        chk("post_rst_score", int'(score), 0);

        // PERFECT at age 50
        pulse_tgt(4'b0010); run_ticks(50);
        expect_hit(H_P, 3, 1, 1, 1'b0, cyc + 2); press(4'b0010);
        // GOOD at age 180
        pulse_tgt(4'b1000); run_ticks(180);
        expect_hit(H_G, 4, 2, 2, 1'b0, cyc + 2); press(4'b1000);
        // Timeout: the tick seen at age 250 misses
        pulse_tgt(4'b0100); run_ticks(250); repeat (3) @(negedge clk);
        expect_hit(H_M, 4, 0, 2, 1'b0, cyc + 1);
        tick = 1'b1; @(negedge clk); tick = 1'b0; repeat (3) @(negedge clk);
        // Wrong/extra buttons
        pulse_tgt(4'b0001); run_ticks(5);
        expect_hit(H_M, 4, 0, 2, 1'b0, cyc + 2); press(4'b1001);
        // Boundary: age 100 still PERFECT
        pulse_tgt(4'b0010); run_ticks(100);
        expect_hit(H_P, 7, 1, 2, 1'b0, cyc + 2); press(4'b0010);
        // Boundary: age 101 is GOOD
        pulse_tgt(4'b0001); run_ticks(101);
        expect_hit(H_G, 8, 2, 2, 1'b0, cyc + 2); press(4'b0001);
        // Boundary: age 250 still GOOD
        pulse_tgt(4'b1000); run_ticks(250);
        expect_hit(H_G, 9, 3, 3, 1'b0, cyc + 2); press(4'b1000);
        // Non-one-hot target ignored; idle press ignored
        pulse_tgt(4'b0011); repeat (2) @(negedge clk);
        press(4'b0010);
        pulse_tgt(4'b0000); press(4'b0001);
        chk("idle_score", int'(score), 9);
        // New target evicts pending arrow as MISS
        pulse_tgt(4'b0010);
        expect_hit(H_M, 9, 0, 3, 1'b0, cyc + 1); pulse_tgt(4'b1000);
        run_ticks(3);
        expect_hit(H_P, 12, 1, 3, 1'b0, cyc + 2); press(4'b1000);
        // Press judged against old arrow in the same cycle a new target arrives
        pulse_tgt(4'b0010); run_ticks(2);
        expect_hit(H_P, 15, 2, 3, 1'b0, cyc + 2);
        btn = 4'b0010; @(negedge clk);
        pulse_tgt(4'b0100); @(negedge clk);
        btn = '0; repeat (3) @(negedge clk);
        expect_hit(H_P, 18, 3, 3, 1'b0, cyc + 2); press(4'b0100);
        // lvl_done with a pending arrow
        pulse_tgt(4'b0100); repeat (2) @(negedge clk);
        expect_hit(H_M, 18, 0, 3, 1'b1, cyc + 1);
        lvl_done = 1'b1; @(negedge clk); lvl_done = 1'b0; repeat (2) @(negedge clk);
        chk("done_final", int'(fin), 1);
        chk("done_max",   int'(maxc), 3);
        // FINISHED ignores targets and presses
        pulse_tgt(4'b0001); press(4'b0001);
        chk("fin_hold_final", int'(fin), 1);
        chk("fin_hold_score", int'(score), 18);
        // start clears everything
        start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
        chk("start_score", int'(score), 0);
        chk("start_combo", int'(combo), 0);
        chk("start_max",   int'(maxc), 0);
        chk("start_final", int'(fin), 0);
        // Play resumes after start
        pulse_tgt(4'b0010); run_ticks(1);
        expect_hit(H_P, 3, 1, 1, 1'b0, cyc + 2); press(4'b0010);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_judge.md
# ddr_judge

Timing judge and scorer sitting directly downstream of the level pattern generators (level1..level4). Consumes the generator's one-cycle target arrow pulses and `done` strobe, compares them against the player's pad buttons within millisecond timing windows, and produces per-arrow judgement pulses plus running score, combo and max-combo for the display stage.

## Interface
- `PERFECT_WIN`, default 100: window in ms ticks after a target, inclusive, for a PERFECT.
- `GOOD_WIN`, default 250: window end in ms ticks, inclusive, for a GOOD; must be greater than `PERFECT_WIN`.
- `clk  in  1` — system clock; one clock, no other domain.
- `rst  in  1` — reset; synchronous, active-high.
- `tick  in  1` — 1 ms strobe, one cycle wide, from the shared timer.
- `start  in  1` — new-song pulse; clears score state.
- `tgt_left`, `tgt_right`, `tgt_up`, `tgt_down`  in  1 each — target pulses from the level generator.
- `lvl_done  in  1` — level generator `done`.
- `btn  in  4` — pad buttons {left, right, up, down}, already synchronised, active-high levels.
- `hit_perfect`, `hit_good`, `hit_miss`  out  1 each — one-cycle judgement pulses.
- `score  out  16` — accumulated points.
- `combo  out  8` — current consecutive non-miss count.
- `max_combo  out  8` — highest combo this song.
- `final  out  1` — song finished; held high.

## Operation
- FSM states: IDLE (no pending arrow), ARMED (pending arrow held in `pend[3:0]`, `age` counting), FINISHED.
- Target capture: the tgt vector is valid only when exactly one-hot. Non-one-hot or all-zero vectors are ignored.
- IDLE + valid target → ARMED, `pend` = vector, `age` = 0.
- ARMED: `age` increments on each `tick`.
- Press: a rising edge on `btn`, detected from two registered copies.
- Press in IDLE: ignored, no score change.
- Press in ARMED, rise vector == `pend`:
  - `age` ≤ `PERFECT_WIN` → PERFECT, +3 points.
  - otherwise → GOOD, +1 point.
  - Either way: combo+1, go to IDLE.
- Press in ARMED, rise vector != `pend` (wrong or extra buttons) → MISS, combo cleared, IDLE.
- Timeout: ARMED with `tick` while `age` == `GOOD_WIN` → MISS, IDLE.
- New valid target while ARMED:
  - A press judged in the same cycle is judged against the old `pend` first.
  - Otherwise the old arrow is judged MISS.
  - In both cases the new target is then armed with `age` = 0.
- `lvl_done`: a pending arrow is judged MISS. Then go to FINISHED, `final` = 1.
- FINISHED ignores targets and presses.
- `start` (any state): clears `score`, `combo`, `max_combo`, `final`, `pend`, `age`; goes to IDLE. `start` beats every simultaneous event, and a same-cycle target is dropped.
- Arithmetic:
  - `score` saturates at 0xFFFF.
  - `combo` saturates at 255.
  - `max_combo` = max(`max_combo`, new `combo`), updated the same cycle as `combo`.
- Reset: all outputs 0, FSM IDLE, edge-detect registers 0. A button held through reset produces no press.

## Timing
- Target pulse at cycle N → ARMED visible at N+1.
- Button rises at input cycle M → judgement pulse high during M+2. `score`, `combo`, `max_combo` update at that same edge.
- Timeout `tick` at cycle T → `hit_miss` at T+1.
- `lvl_done` at cycle D → `hit_miss` (if pending) and `final` both at D+1.
- Exactly one `hit_*` pulse per judged arrow; never two in one cycle.
- Reset mid-ARMED discards the pending arrow without a MISS pulse.

## Configuration
- `DDR_JUDGE_COMBO_BONUS_EN` defined: PERFECT awards 3 + min(combo before the hit, 15) / 4 points. GOOD is unchanged.
- Undefined: fixed 3/1/0 points. No bonus logic is synthesised.

## Structure
- `ddr_pkg` holds:
  - Judgement enum {J_NONE, J_PERFECT, J_GOOD, J_MISS}.
  - FSM state enum.
  - Point constants `PTS_PERFECT` = 3, `PTS_GOOD` = 1.
  - Direction bit order {LEFT, RIGHT, UP, DOWN}.
- Sub-module `ddr_edge_detect`: 4-bit two-register rising-edge detector with synchronous reset.

## Test plan
- Reset held 3 cycles with `btn` = 4'b1111 → all outputs 0. Releasing reset with buttons still held → no pulses.
- `tgt_up`, then up pressed after 50 ticks → `hit_perfect` at M+2, `score` = 3, `combo` = 1.
- `tgt_left`, then left pressed after 180 ticks → `hit_good`, `score` += 1.
- `tgt_right` with no press → `hit_miss` one cycle after tick 250, `combo` = 0, `max_combo` retains its prior value.
- `tgt_down`, then left+down pressed together → `hit_miss`, combo cleared.
- Target pending, then `lvl_done` → `hit_miss` and `final` = 1 together. A later `start` → all counters 0, `final` = 0.
